// File: rtl/vx_cache_fill_sched.sv
// vx_cache_fill_sched
//   Per-bank memory-response scheduler. Returning line fills, tagged with the
//   MSHR id that issued the miss, are buffered in a FIFO and issued one at a
//   time into the bank pipeline. After each fill the scheduler waits for the
//   MSHR replay chain that fill started to drain before it offers the next
//   fill. The MSHR tracks only one replay chain, and a new fill would
//   overwrite its dequeue pointer.
//
//   Optional feature macro: VX_CACHE_FILL_PERF_EN (stall-cycle counter).
//
//   Ports
//     clk, reset          clock, synchronous active-high reset
//     mem_rsp_*_i/o       memory response in (valid/id/data, ready out)
//     fill_*_o/i          fill request to bank pipeline (valid/id/data, ready in)
//     replay_active_i     MSHR dequeue_valid (replay chain in flight)
//     pending_count_o     FIFO occupancy
//     perf_stall_cycles_o stalled fill cycles (0 when feature disabled)
//
//   state | meaning
//   IDLE  | may issue the FIFO head once replay_active_i is low
//   ARM   | fill accepted, waiting FILL_LAT for the MSHR to raise replay_active
//   DRAIN | waiting for the replay chain to finish
module vx_cache_fill_sched #(
  parameter int LINE_SIZE       = 16,
  parameter int MSHR_SIZE       = 4,
  parameter int MSHR_ADDR_WIDTH = (MSHR_SIZE > 1) ? $clog2(MSHR_SIZE) : 1,
  parameter int RSP_QUEUE_SIZE  = 4,
  parameter int FILL_LAT        = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                mem_rsp_valid_i,
  input  logic [MSHR_ADDR_WIDTH-1:0]          mem_rsp_id_i,
  input  logic [LINE_SIZE*8-1:0]              mem_rsp_data_i,
  output logic                                mem_rsp_ready_o,
  output logic                                fill_valid_o,
  output logic [MSHR_ADDR_WIDTH-1:0]          fill_id_o,
  output logic [LINE_SIZE*8-1:0]              fill_data_o,
  input  logic                                fill_ready_i,
  input  logic                                replay_active_i,
  output logic [$clog2(RSP_QUEUE_SIZE):0]     pending_count_o,
  output logic [31:0]                         perf_stall_cycles_o
);

  localparam int DW   = LINE_SIZE * 8;
  localparam int EW   = MSHR_ADDR_WIDTH + DW;
  localparam int QAW  = $clog2(RSP_QUEUE_SIZE);
  localparam int CNTW = QAW + 1;
  localparam int WCW  = (FILL_LAT > 1) ? $clog2(FILL_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ARM, DRAIN} state_t;

  state_t          state_q;
  logic [WCW-1:0]  wait_cnt_q;
  logic [EW-1:0]   mem_q [RSP_QUEUE_SIZE];
  logic [QAW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNTW-1:0] count_q, count_d;
  logic            full, empty, push, pop;

  assign full  = (count_q == CNTW'(RSP_QUEUE_SIZE));
  assign empty = (count_q == '0);

  // Held low while reset is asserted so nothing is accepted into a FIFO
  // that is being flushed.
  assign mem_rsp_ready_o = !reset && !full;
  assign push            = mem_rsp_valid_i && mem_rsp_ready_o;

  assign fill_valid_o = (state_q == IDLE) && !empty && !replay_active_i;
  assign pop          = fill_valid_o && fill_ready_i;

  assign {fill_id_o, fill_data_o} = mem_q[rd_ptr_q];
  assign pending_count_o          = count_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Line storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {mem_rsp_id_i, mem_rsp_data_i};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case (state_q)
        IDLE: begin
          if (pop) begin
            wait_cnt_q <= WCW'(FILL_LAT - 1);
            state_q    <= ARM;
          end
        end
        ARM: begin
          // replay_active may still reflect the previous chain here; the
          // MSHR only raises it for this fill after FILL_LAT cycles.
          if (wait_cnt_q == '0) state_q    <= DRAIN;
          else                  wait_cnt_q <= wait_cnt_q - 1'b1;
        end
        DRAIN: begin
          if (!replay_active_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef VX_CACHE_FILL_PERF_EN
  logic        stall;
  logic [31:0] perf_q;

  assign stall = !empty && ((state_q != IDLE) || replay_active_i || !fill_ready_i);

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_q <= '0;
    end else if (stall && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_stall_cycles_o = perf_q;
`else
  assign perf_stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_vx_cache_fill_sched.sv
module tb_vx_cache_fill_sched;

  localparam int FILL_LAT = 2;
  localparam int DW       = 128;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mem_rsp_valid = 1'b0;
  logic [1:0]    mem_rsp_id = '0;
  logic [DW-1:0] mem_rsp_data = '0;
  logic          mem_rsp_ready;
  logic          fill_valid;
  logic [1:0]    fill_id;
  logic [DW-1:0] fill_data;
  logic          fill_ready = 1'b0;
  logic          replay_active = 1'b0;
  logic [2:0]    pending_count;
  logic [31:0]   perf_stall_cycles;

  vx_cache_fill_sched #(
    .LINE_SIZE(16), .MSHR_SIZE(4), .RSP_QUEUE_SIZE(4), .FILL_LAT(FILL_LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .mem_rsp_valid_i(mem_rsp_valid), .mem_rsp_id_i(mem_rsp_id),
    .mem_rsp_data_i(mem_rsp_data), .mem_rsp_ready_o(mem_rsp_ready),
    .fill_valid_o(fill_valid), .fill_id_o(fill_id), .fill_data_o(fill_data),
    .fill_ready_i(fill_ready), .replay_active_i(replay_active),
    .pending_count_o(pending_count), .perf_stall_cycles_o(perf_stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    id;
    logic [DW-1:0] data;
    int            gap;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int hs_cyc = -100;
  int hs_cnt = 0;
  int rp_len = 0;
  int conc_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] mkdata(input logic [7:0] b);
    return {16{b}};
  endfunction

  // MSHR model: replay chain visible FILL_LAT cycles after each handshake.
  always @(posedge clk) begin
    #1;
    replay_active = (cyc >= hs_cyc + FILL_LAT) && (cyc < hs_cyc + FILL_LAT + rp_len);
  end

  // Monitor: fill scoreboard, hold-under-backpressure and occupancy model.
  logic          prev_stall = 1'b0;
  logic [1:0]    held_id;
  logic [DW-1:0] held_data;
  int            exp_pc = -1;
  int            last_hs = -100;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
      exp_pc     = 0;
    end else begin
      if (exp_pc >= 0) chk("occupancy", DW'(pending_count), DW'(exp_pc));
      if (prev_stall) begin
        chk("hold_valid", DW'(fill_valid), DW'(1));
        chk("hold_id", DW'(fill_id), DW'(held_id));
        chk("hold_data", fill_data, held_data);
      end
      prev_stall = fill_valid && !fill_ready;
      held_id    = fill_id;
      held_data  = fill_data;
      exp_pc = int'(pending_count) + int'(mem_rsp_valid && mem_rsp_ready)
             - int'(fill_valid && fill_ready);
      if (mem_rsp_valid && mem_rsp_ready && fill_valid && fill_ready) conc_cnt++;
      if (fill_valid && fill_ready) begin
        hs_cnt++;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_fill: got id %0d with no pending expectation", fill_id);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("fill_id", DW'(fill_id), DW'(e.id));
          chk("fill_data", fill_data, e.data);
          if (e.gap >= 0) chk("fill_gap", DW'(cyc - last_hs), DW'(e.gap));
        end
        last_hs = cyc;
        hs_cyc  = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] id, input logic [7:0] b, input int gap);
    bit done = 0;
    mem_rsp_valid = 1'b1;
    mem_rsp_id    = id;
    mem_rsp_data  = mkdata(b);
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (mem_rsp_ready) begin
        exp_t e;
        e.id = id; e.data = mkdata(b); e.gap = gap;
        sb.push_back(e);
        done = 1;
      end
      step();
    end
    mem_rsp_valid = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL push_timeout: id %0d never accepted", id);
    end
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && pending_count == 0 && !fill_valid) done = 1;
      step();
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL drain_timeout: %0d fills outstanding", sb.size());
    end
    repeat (8) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] perf_a;
    int hs0;
    bit seen;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", DW'(mem_rsp_ready), DW'(0));
    chk("rst_fill_valid", DW'(fill_valid), DW'(0));
    chk("rst_pending", DW'(pending_count), DW'(0));
    chk("rst_perf", DW'(perf_stall_cycles), DW'(0));
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", DW'(mem_rsp_ready), DW'(1));
    step();

    // Single fill, next fill held until replay chain drains
    fill_ready = 1'b1;
    rp_len = 3;
    push(2'd2, 8'hA5, -1);
    push(2'd1, 8'h3C, FILL_LAT + 1 + rp_len);
    wait_drain();

    // Back-to-back with immediate drain: FILL_LAT+2 spacing
    rp_len = 0;
    push(2'd1, 8'h11, -1);
    push(2'd3, 8'h33, FILL_LAT + 2);
    push(2'd0, 8'h44, FILL_LAT + 2);
    wait_drain();

    // Full FIFO
    fill_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(2'(i), 8'h50 + 8'(i), -1);
    @(negedge clk);
    chk("full_ready", DW'(mem_rsp_ready), DW'(0));
    chk("full_pending", DW'(pending_count), DW'(4));
    step();
    mem_rsp_valid = 1'b1;
    mem_rsp_id    = 2'd1;
    mem_rsp_data  = mkdata(8'h99);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("full_reject", DW'(pending_count), DW'(4));
      step();
    end
    mem_rsp_valid = 1'b0;
    fill_ready = 1'b1;
    step();
    @(negedge clk);
    chk("pop_ready", DW'(mem_rsp_ready), DW'(1));
    chk("pop_pending", DW'(pending_count), DW'(3));
    step();
    wait_drain();

    // Backpressure for 5 cycles
    fill_ready = 1'b0;
    push(2'd2, 8'h77, -1);
    @(negedge clk);
    perf_a = perf_stall_cycles;
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      chk("bp_pending", DW'(pending_count), DW'(1));
    end
`ifdef VX_CACHE_FILL_PERF_EN
    chk("bp_perf_delta", DW'(perf_stall_cycles - perf_a), DW'(5));
`endif
    step();
    fill_ready = 1'b1;
    wait_drain();

    // Wrap-around stream of 10
    conc_cnt = 0;
    for (int i = 0; i < 10; i++) push(2'(i % 4), 8'h60 + 8'(i), -1);
    wait_drain();
    total++;
    if (conc_cnt == 0) begin
      bad++;
      $display("FAIL concurrent_push_pop: got 0 cycles expected >0");
    end

    // Reset in DRAIN with two entries queued
    rp_len = 20;
    hs0 = hs_cnt;
    fork
      begin
        push(2'd1, 8'h81, -1);
        push(2'd2, 8'h82, -1);
        push(2'd3, 8'h83, -1);
      end
    join_none
    seen = 0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      if (hs_cnt != hs0) seen = 1;
      step();
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL drain_handshake_timeout: got none expected one fill");
    end
    wait fork;
    repeat (3) step();
    @(negedge clk);
    chk("drain_pending", DW'(pending_count), DW'(2));
    chk("drain_blocked", DW'(fill_valid), DW'(0));
    step();
    reset = 1'b1;
    rp_len = 0;
    hs_cyc = -100;
    sb.delete();
    @(negedge clk);
    chk("rst_mid_ready", DW'(mem_rsp_ready), DW'(0));
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_pending", DW'(pending_count), DW'(0));
    chk("rst_mid_fill_valid", DW'(fill_valid), DW'(0));
    chk("rst_mid_perf", DW'(perf_stall_cycles), DW'(0));
    for (int i = 0; i < 6; i++) begin
      step();
      @(negedge clk);
      chk("no_reissue", DW'(fill_valid), DW'(0));
    end
    step();

    chk("sb_empty", DW'(sb.size()), DW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
